// File: rtl/fpga_state_pkg.sv
// Shared definitions for the FPGA runtime-state writer and the controller
// that reads the same BRAM region back over the CPU bus.
package fpga_state_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_WAIT,
        W0,
        W1,
        W2,
        W3,
        DONE
    } state_t;

    localparam int BIT_THERMO    = 0;
    localparam int BIT_FORCE_FAN = 1;
    localparam int BIT_OP_MODE   = 2;
    localparam int BIT_STM_GAIN  = 3;
    localparam int BIT_SYNC_DONE = 4;

    localparam logic [13:0] DEF_ADDR_FPGA_STATE = 14'h0000;
    localparam logic [13:0] DEF_ADDR_MOD_IDX    = 14'h0001;
    localparam logic [13:0] DEF_ADDR_STM_IDX    = 14'h0002;
    localparam logic [13:0] DEF_ADDR_SYNC_CNT   = 14'h0003;

    function automatic logic [15:0] pack_state(
        input logic thermo,
        input logic force_fan,
        input logic op_mode,
        input logic stm_gain,
        input logic sync_done
    );
        logic [15:0] w;
        w                = '0;
        w[BIT_THERMO]    = thermo;
        w[BIT_FORCE_FAN] = force_fan;
        w[BIT_OP_MODE]   = op_mode;
        w[BIT_STM_GAIN]  = stm_gain;
        w[BIT_SYNC_DONE] = sync_done;
        return w;
    endfunction

endpackage

// File: rtl/fpga_state_writer.sv
// Writes a four-word snapshot of FPGA runtime state into the controller BRAM
// over a shared port B, periodically and whenever the packed state changes.
module fpga_state_writer
    import fpga_state_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 14,
    parameter logic [ADDR_WIDTH-1:0] ADDR_FPGA_STATE = ADDR_WIDTH'(DEF_ADDR_FPGA_STATE),
    parameter logic [ADDR_WIDTH-1:0] ADDR_MOD_IDX    = ADDR_WIDTH'(DEF_ADDR_MOD_IDX),
    parameter logic [ADDR_WIDTH-1:0] ADDR_STM_IDX    = ADDR_WIDTH'(DEF_ADDR_STM_IDX),
    parameter logic [ADDR_WIDTH-1:0] ADDR_SYNC_CNT   = ADDR_WIDTH'(DEF_ADDR_SYNC_CNT),
    parameter int                    UPDATE_PERIOD   = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  THERMO,
    input  logic                  FORCE_FAN,
    input  logic                  OP_MODE,
    input  logic                  STM_GAIN_MODE,
    input  logic                  SYNC_SET,
    input  logic [15:0]           MOD_IDX,
    input  logic [15:0]           STM_IDX,
    output logic                  REQ,
    input  logic                  GNT,
    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [15:0]           BRAM_DIN
);

    localparam int PW = $clog2(UPDATE_PERIOD);

    state_t                state;
    logic [PW-1:0]         period_cnt;
    logic [15:0]           sync_cnt;
    logic                  sync_done;
    logic                  pending;
    logic [15:0]           prev_word;
    logic [15:0]           snap_mod;
    logic [15:0]           snap_stm;
    logic [15:0]           snap_sync;
    logic                  req_q;
    logic                  en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           din_q;

    logic [15:0] state_word;
    logic [15:0] sync_next;
    logic        wrap;
    logic        trigger;
    logic        writing;

    assign state_word = pack_state(THERMO, FORCE_FAN, OP_MODE,
                                   STM_GAIN_MODE, sync_done);
    assign sync_next  = sync_cnt + 16'(SYNC_SET);
    assign wrap       = period_cnt == PW'(UPDATE_PERIOD - 1);
    assign trigger    = wrap | (state_word != prev_word);
    assign writing    = state inside {W0, W1, W2, W3};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            period_cnt <= '0;
            sync_cnt   <= '0;
            sync_done  <= 1'b0;
            pending    <= 1'b0;
            prev_word  <= '0;
            snap_mod   <= '0;
            snap_stm   <= '0;
            snap_sync  <= '0;
            req_q      <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            prev_word  <= state_word;
            period_cnt <= wrap ? '0 : period_cnt + 1'b1;
            sync_cnt   <= sync_next;
            pending    <= pending | trigger;
            if (SYNC_SET) sync_done <= 1'b1;

            // Losing the grant mid-burst abandons it; the next grant resnaps.
            if (writing && !GNT) begin
                state  <= REQ_WAIT;
                en_q   <= 1'b0;
                addr_q <= '0;
                din_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            state   <= REQ_WAIT;
                            req_q   <= 1'b1;
                            pending <= trigger;
                        end
                    end
                    REQ_WAIT: begin
                        if (GNT) begin
                            snap_mod  <= MOD_IDX;
                            snap_stm  <= STM_IDX;
                            snap_sync <= sync_next;
                            state     <= W0;
                            en_q      <= 1'b1;
                            addr_q    <= ADDR_FPGA_STATE;
                            din_q     <= state_word;
                        end
                    end
                    W0: begin
                        state  <= W1;
                        addr_q <= ADDR_MOD_IDX;
                        din_q  <= snap_mod;
                    end
                    W1: begin
                        state  <= W2;
                        addr_q <= ADDR_STM_IDX;
                        din_q  <= snap_stm;
                    end
                    W2: begin
                        state  <= W3;
                        addr_q <= ADDR_SYNC_CNT;
                        din_q  <= snap_sync;
                    end
                    W3: begin
                        state  <= DONE;
                        req_q  <= 1'b0;
                        en_q   <= 1'b0;
                        addr_q <= '0;
                        din_q  <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign REQ       = req_q;
    assign BRAM_EN   = en_q & GNT;
    assign BRAM_WE   = en_q & GNT;
    assign BRAM_ADDR = BRAM_EN ? addr_q : '0;
    assign BRAM_DIN  = BRAM_EN ? din_q : '0;

endmodule

// File: tb/tb_fpga_state_writer.sv
// Scoreboard bench for fpga_state_writer: expected BRAM writes are queued
// by the stimulus and popped by an independent write monitor.
module tb_fpga_state_writer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        THERMO = 1'b0;
    logic        FORCE_FAN = 1'b0;
    logic        OP_MODE = 1'b0;
    logic        STM_GAIN_MODE = 1'b0;
    logic        SYNC_SET = 1'b0;
    logic [15:0] MOD_IDX = '0;
    logic [15:0] STM_IDX = '0;
    logic        REQ;
    logic        GNT = 1'b0;
    logic        BRAM_EN;
    logic        BRAM_WE;
    logic [13:0] BRAM_ADDR;
    logic [15:0] BRAM_DIN;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [29:0] exp_q[$];
    logic [29:0] e;

    fpga_state_writer dut (
        .CLK          (CLK),
        .RST          (RST),
        .THERMO       (THERMO),
        .FORCE_FAN    (FORCE_FAN),
        .OP_MODE      (OP_MODE),
        .STM_GAIN_MODE(STM_GAIN_MODE),
        .SYNC_SET     (SYNC_SET),
        .MOD_IDX      (MOD_IDX),
        .STM_IDX      (STM_IDX),
        .REQ          (REQ),
        .GNT          (GNT),
        .BRAM_EN      (BRAM_EN),
        .BRAM_WE      (BRAM_WE),
        .BRAM_ADDR    (BRAM_ADDR),
        .BRAM_DIN     (BRAM_DIN)
    );

    always #5 CLK = ~CLK;

    // cyc equals the DUT period counter value in the interval after each edge
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [13:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic outs_zero(input string name);
        chk({name, "_req"}, 32'(REQ), 0);
        chk({name, "_en"}, 32'(BRAM_EN), 0);
        chk({name, "_we"}, 32'(BRAM_WE), 0);
        chk({name, "_addr"}, 32'(BRAM_ADDR), 0);
        chk({name, "_din"}, 32'(BRAM_DIN), 0);
    endtask

    // Called at a negedge; leaves RST released at a negedge with cyc == 0.
    task automatic do_reset(input logic gnt);
        RST = 1'b1;
        THERMO = 0; FORCE_FAN = 0; OP_MODE = 0; STM_GAIN_MODE = 0;
        SYNC_SET = 0; MOD_IDX = '0; STM_IDX = '0; GNT = gnt;
        repeat (3) @(negedge CLK);
        outs_zero("reset");
        RST = 1'b0;
    endtask

    task automatic quiet_until(input string name, input int n);
        int bad = 0;
        while (cyc < n) begin
            @(negedge CLK);
            if (BRAM_WE) bad++;
        end
        chk(name, 32'(bad), 0);
    endtask

    // Write monitor
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (BRAM_EN && BRAM_WE) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none (cycle %0d)",
                             BRAM_ADDR, BRAM_DIN, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(BRAM_ADDR), 32'(e[29:16]));
                    chk("write_data", 32'(BRAM_DIN), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int bad;
        @(negedge CLK);

        // 1: reset state, then first periodic burst at UPDATE_PERIOD+2
        do_reset(1'b1);
        push(14'h0, 16'h0000); push(14'h1, 16'h0000);
        push(14'h2, 16'h0000); push(14'h3, 16'h0000);
        quiet_until("periodic_quiet", 257);
        chk("periodic_req257", 32'(REQ), 1);
        at_cycle(258);
        chk("periodic_we258", 32'(BRAM_WE), 1);
        at_cycle(262);
        chk("periodic_req_low", 32'(REQ), 0);

        // 2: THERMO change at cycle 100
        @(negedge CLK);
        do_reset(1'b1);
        push(14'h0, 16'h0001); push(14'h1, 16'h0000);
        push(14'h2, 16'h0000); push(14'h3, 16'h0000);
        at_cycle(100);
        THERMO = 1'b1;
        at_cycle(101);
        chk("thermo_req101", 32'(REQ), 0);
        at_cycle(102);
        chk("thermo_req102", 32'(REQ), 1);
        at_cycle(103);
        chk("thermo_we103", 32'(BRAM_WE), 1);
        chk("thermo_addr103", 32'(BRAM_ADDR), 0);
        at_cycle(106);
        chk("thermo_req106", 32'(REQ), 1);
        at_cycle(107);
        chk("thermo_req107", 32'(REQ), 0);

        // 3: grant arrives 10 cycles after REQ; snapshot taken at grant
        @(negedge CLK);
        do_reset(1'b0);
        push(14'h0, 16'h0002); push(14'h1, 16'h1234);
        push(14'h2, 16'hBEEF); push(14'h3, 16'h0000);
        at_cycle(20);
        FORCE_FAN = 1'b1;
        at_cycle(21);
        chk("late_req21", 32'(REQ), 0);
        bad = 0;
        for (int c = 22; c <= 31; c++) begin
            at_cycle(c);
            if (!REQ || BRAM_WE) bad++;
        end
        chk("late_wait_window", 32'(bad), 0);
        at_cycle(32);
        GNT = 1'b1; MOD_IDX = 16'h1234; STM_IDX = 16'hBEEF;
        at_cycle(33);
        chk("late_we33", 32'(BRAM_WE), 1);
        MOD_IDX = 16'h5555; STM_IDX = 16'h6666;
        at_cycle(36);
        chk("late_we36", 32'(BRAM_WE), 1);
        at_cycle(37);
        chk("late_req37", 32'(REQ), 0);

        // 4: grant lost in W2, restart with a fresh snapshot
        @(negedge CLK);
        do_reset(1'b1);
        MOD_IDX = 16'h0A0A; STM_IDX = 16'h0B0B;
        push(14'h0, 16'h0001); push(14'h1, 16'h0A0A);
        push(14'h0, 16'h0001); push(14'h1, 16'h0C0C);
        push(14'h2, 16'h0B0B); push(14'h3, 16'h0000);
        at_cycle(10);
        THERMO = 1'b1;
        at_cycle(15);
        chk("drop_we_before", 32'(BRAM_WE), 1);
        GNT = 1'b0;
        #1;
        chk("drop_we", 32'(BRAM_WE), 0);
        chk("drop_en", 32'(BRAM_EN), 0);
        chk("drop_addr", 32'(BRAM_ADDR), 0);
        chk("drop_req", 32'(REQ), 1);
        at_cycle(16);
        chk("drop_req16", 32'(REQ), 1);
        MOD_IDX = 16'h0C0C;
        at_cycle(17);
        GNT = 1'b1;
        at_cycle(18);
        chk("regrant_we18", 32'(BRAM_WE), 1);
        chk("regrant_addr18", 32'(BRAM_ADDR), 0);
        at_cycle(22);
        chk("regrant_req22", 32'(REQ), 0);

        // 5: reset during W1, then nothing until the period trigger
        @(negedge CLK);
        do_reset(1'b1);
        push(14'h0, 16'h0001);
        at_cycle(10);
        THERMO = 1'b1;
        at_cycle(14);
        chk("rstw1_we_before", 32'(BRAM_WE), 1);
        RST = 1'b1;
        THERMO = 1'b0;
        #1;
        outs_zero("rst_mid");
        @(negedge CLK);
        do_reset(1'b1);
        push(14'h0, 16'h0000); push(14'h1, 16'h0000);
        push(14'h2, 16'h0000); push(14'h3, 16'h0000);
        quiet_until("post_rst_quiet", 257);
        at_cycle(258);
        chk("post_rst_we258", 32'(BRAM_WE), 1);
        at_cycle(262);

        // 6: 65537 SYNC_SET cycles wrap the counter to 1, sync_done set
        @(negedge CLK);
        do_reset(1'b0);
        at_cycle(5);
        SYNC_SET = 1'b1;
        at_cycle(5 + 65537);
        SYNC_SET = 1'b0;
        at_cycle(65545);
        chk("sync_req", 32'(REQ), 1);
        push(14'h0, 16'h0010); push(14'h1, 16'h0000);
        push(14'h2, 16'h0000); push(14'h3, 16'h0001);
        GNT = 1'b1;
        at_cycle(65546);
        chk("sync_we", 32'(BRAM_WE), 1);
        at_cycle(65550);
        chk("sync_req_low", 32'(REQ), 0);
        GNT = 1'b0;

        repeat (4) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_state_writer.md
Name: fpga_state_writer

Overview:
- Write-side counterpart of the controller's CPU-bus register reader.
- Periodically, and on any status change, writes a snapshot of FPGA runtime state into the controller BRAM region, where the CPU reads it back.
- Shares BRAM port B with the controller through a REQ/GNT handshake; the controller arbitrates and owns the port.

Parameters:
- ADDR_WIDTH, 14, BRAM word address width.
- ADDR_FPGA_STATE, 14'h0000, word address of the packed state word.
- ADDR_MOD_IDX, 14'h0001, word address of the current modulation index.
- ADDR_STM_IDX, 14'h0002, word address of the current STM index.
- ADDR_SYNC_CNT, 14'h0003, word address of the SYNC_SET event counter.
- UPDATE_PERIOD, 256, CLK cycles between periodic refreshes (≥ 8).

Ports:
- CLK  in  1  system clock (20.48 MHz).
- RST  in  1  asynchronous, active-high reset.
- THERMO  in  1  thermal alarm.
- FORCE_FAN  in  1  fan force flag.
- OP_MODE  in  1  0 = modulation/gain, 1 = STM.
- STM_GAIN_MODE  in  1  STM gain-mode flag.
- SYNC_SET  in  1  single-cycle pulse marking completion of an ECAT sync.
- MOD_IDX  in  16  current modulation sample index.
- STM_IDX  in  16  current STM sample index.
- REQ  out  1  port-B request to the controller.
- GNT  in  1  port-B grant from the controller.
- BRAM_EN  out  1  port-B enable.
- BRAM_WE  out  1  port-B write enable.
- BRAM_ADDR  out  ADDR_WIDTH  port-B word address.
- BRAM_DIN  out  16  port-B write data.

Behaviour:
- Reset (async, RST=1): all outputs 0; FSM = IDLE; period counter, sync counter, sync_done and pending all cleared. Reset at any point, including mid-write, aborts immediately; no partial-write recovery is needed because the next sequence rewrites all four words.
- State word: {11'b0, sync_done, STM_GAIN_MODE, OP_MODE, FORCE_FAN, THERMO}, bit 0 = THERMO.
  - sync_done: set on the first SYNC_SET after reset; cleared only by reset.
- Sync counter: 16-bit; +1 on each SYNC_SET cycle; wraps 16'hFFFF → 0.
- Period counter: counts 0..UPDATE_PERIOD-1, then wraps. The wrap cycle raises a trigger.
- Change trigger: the state word differs from its registered previous-cycle value.
- Any trigger sets pending. pending clears when the FSM leaves IDLE. A trigger in any non-IDLE state leaves pending set.
- FSM states:
  - IDLE: if pending → REQ_WAIT, with REQ=1 on the next cycle.
  - REQ_WAIT: REQ=1. On the cycle GNT=1 is sampled, latch the snapshot (state word, MOD_IDX, STM_IDX, sync counter) → W0.
  - W0..W3: REQ=1, BRAM_EN=1, BRAM_WE=1. Each state drives one address/data pair from the snapshot:
    - W0: ADDR_FPGA_STATE / state word.
    - W1: ADDR_MOD_IDX / MOD_IDX.
    - W2: ADDR_STM_IDX / STM_IDX.
    - W3: ADDR_SYNC_CNT / sync counter.
    - W0→W1→W2→W3→DONE.
  - DONE: REQ=0, EN=0, WE=0 → IDLE.
- Outputs are registered. Latency:
  - Trigger at cycle t → pending at t+1 → REQ high at t+2.
  - GNT sampled at cycle g → writes in g+1..g+4 → REQ low at g+5.
- GNT loss: GNT=0 in any Wn state → WE/EN drop that same cycle (combinational gate on the registered strobe), FSM → REQ_WAIT. The sequence restarts from W0 with a fresh snapshot at the next grant.
- Simultaneous events:
  - SYNC_SET on the snapshot cycle is counted before capture, so the snapshot holds the incremented value.
  - Period wrap and a change trigger together set pending once.
- BRAM_ADDR and BRAM_DIN are 0 whenever BRAM_EN=0.

Decomposition:
- Package fpga_state_pkg holds:
  - the FSM state enum (IDLE, REQ_WAIT, W0, W1, W2, W3, DONE);
  - state-word bit-position constants;
  - default address localparams shared with the controller.
- No sub-module is needed; the snapshot/mux is inline.

Test Plan:
- Reset → all outputs 0. Release RST, GNT held at 1, all inputs 0 → the first write burst starts at cycle UPDATE_PERIOD+2 and writes words 0x0000, 0, 0, 0 to addresses 0..3.
- GNT=1 always, THERMO 0→1 at cycle 100 → REQ at 102; W0 at 103 writes 16'h0001 at address 0; REQ low at 107.
- GNT asserted 10 cycles after REQ → no WE while waiting. Then 4 consecutive WE cycles writing MOD_IDX=16'h1234 and STM_IDX=16'hBEEF as sampled at grant.
- 65537 SYNC_SET pulses, then a trigger → sync word reads 16'h0001 (wrap), and state-word bit 4 = 1.
- GNT dropped during W2 → WE=0 that cycle, REQ stays 1. Re-grant → full restart at W0 with all four words rewritten.
- RST pulsed during W1 → outputs 0 within the same cycle. After release, the first write occurs only after the period or change trigger.
